// File: rtl/traceback_column_writer.sv
// Write side of the traceback direction memory: deskews the PE wavefront into
// per-column words and writes one N-entry column word per aligned strobe.
module traceback_column_writer #(
  parameter int N               = 16,
  parameter int DIRECTION_WIDTH = 5,
  parameter int POSITION_WIDTH  = 10,
  parameter int ADDR_WIDTH      = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [POSITION_WIDTH-1:0]     col_len_i,
  input  logic [$clog2(N):0]            row_count_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic [N-1:0]                  pe_valid_i,
  input  logic [N*DIRECTION_WIDTH-1:0]  pe_dir_i,
  output logic                          mem_wen_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [N*DIRECTION_WIDTH-1:0]  mem_wdata_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          skew_err_o,
  output logic [1:0]                    dbg_state_o
);

  localparam int DW  = DIRECTION_WIDTH;
  localparam int RCW = $clog2(N) + 1;

  // Write port is valid-only: mem_wen_o qualifies addr/data for exactly one
  // cycle and the memory has no ready; it must accept a write every cycle.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [POSITION_WIDTH-1:0] len_q;
  logic [POSITION_WIDTH-1:0] c_q;
  logic [RCW-1:0]          row_cnt_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic                    skew_q;
  logic                    mem_wen_q;
  logic                    last_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [N*DW-1:0]         wdata_q;

  logic [N-1:0]            dly_v;
  logic [DW-1:0]           dly_dir [N];

  // Row i waits N-1-i cycles so every row of a column lands in the same cycle.
  for (genvar i = 0; i < N; i++) begin : g_row
    localparam int D = N - 1 - i;
    if (D == 0) begin : g_nodly
      assign dly_v[i]   = pe_valid_i[i];
      assign dly_dir[i] = pe_dir_i[i*DW +: DW];
    end else begin : g_dly
      logic [D-1:0]  v_q;
      logic [DW-1:0] d_q [D];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= '0;
          for (int k = 0; k < D; k++) d_q[k] <= '0;
        end else begin
          v_q[0] <= pe_valid_i[i];
          d_q[0] <= pe_dir_i[i*DW +: DW];
          for (int k = 1; k < D; k++) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end
      assign dly_v[i]   = v_q[D-1];
      assign dly_dir[i] = d_q[D-1];
    end
  end

  logic            al_v;
  logic [N*DW-1:0] al_word;
  logic            mis;
  logic            wr_accept;
  logic            extra;
  logic            skew_set;

  assign al_v = dly_v[0];

  // Rows beyond row_count are forced to zero and excluded from the skew check.
  always_comb begin
    al_word = '0;
    mis     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (RCW'(i) < row_cnt_q) begin
        al_word[(N-1-i)*DW +: DW] = dly_dir[i];
        if (dly_v[i] != al_v) mis = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_accept = 1'b0;
    extra     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (col_len_i == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (al_v) begin
          if (c_q != len_q) wr_accept = 1'b1;
          else              extra     = 1'b1;
        end
        if (last_q) state_d = S_DONE;
      end
      S_DONE: begin
        extra   = al_v;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign skew_set = (state_q != S_IDLE) && (mis || extra);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      c_q       <= '0;
      row_cnt_q <= '0;
      base_q    <= '0;
      skew_q    <= 1'b0;
      mem_wen_q <= 1'b0;
      last_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start_i) begin
        len_q     <= col_len_i;
        row_cnt_q <= row_count_i;
        base_q    <= base_addr_i;
        c_q       <= '0;
        skew_q    <= 1'b0;
      end else begin
        if (wr_accept) c_q    <= c_q + 1'b1;
        if (skew_set)  skew_q <= 1'b1;
      end
      mem_wen_q <= wr_accept;
      // last_q rides alongside the final write so done follows it by one cycle.
      last_q    <= wr_accept && (c_q == len_q - 1'b1);
      if (wr_accept) begin
        addr_q  <= base_q + ADDR_WIDTH'(c_q);
        wdata_q <= al_word;
      end
    end
  end

  assign mem_wen_o   = mem_wen_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign skew_err_o  = skew_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_traceback_column_writer.sv
// Bench for traceback_column_writer: random wavefronts against a column-level
// model of which words land at which address and cycle.
module tb_traceback_column_writer;

  localparam int N   = 16;
  localparam int DW  = 5;
  localparam int PW  = 10;
  localparam int AW  = 10;
  localparam int RCW = 5;
  localparam int W   = AW + N*DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [PW-1:0]   col_len;
  logic [RCW-1:0]  row_count;
  logic [AW-1:0]   base_addr;
  logic [N-1:0]    pe_valid;
  logic [N*DW-1:0] pe_dir;
  logic            mem_wen;
  logic [AW-1:0]   mem_addr;
  logic [N*DW-1:0] mem_wdata;
  logic            busy;
  logic            done;
  logic            skew_err;
  logic [1:0]      dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int wr_seen      = 0;
  int done_cnt     = 0;
  int done_cyc     = -1;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  traceback_column_writer #(
    .N(N), .DIRECTION_WIDTH(DW), .POSITION_WIDTH(PW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .col_len_i(col_len),
    .row_count_i(row_count), .base_addr_i(base_addr), .pe_valid_i(pe_valid),
    .pe_dir_i(pe_dir), .mem_wen_o(mem_wen), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .busy_o(busy), .done_o(done),
    .skew_err_o(skew_err), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wen) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_wr", mem_wen, 1'b0);
        end else begin
          logic [W-1:0] e;
          int           ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check_eq("wr_addr", mem_addr, e[W-1 -: AW]);
          check_eq("wr_data", mem_wdata, e[N*DW-1:0]);
          check_eq("wr_cycle", cyc, ec);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_stripe(input int len, input int rows, input int base,
                            input int drop_row, input int drop_col, input int extra_cols,
                            input int gap, input bit fixed, input string tag);
    logic [DW-1:0]   code [32][N];
    bit              vld  [32][N];
    logic [N*DW-1:0] d;
    int ncols, t0, k, last_c, exp_done, wr0, done0, c, wait_n;
    bit exp_skew, s;
    ncols = len + extra_cols;
    for (int cc = 0; cc < ncols; cc++)
      for (int i = 0; i < N; i++) begin
        vld[cc][i]  = !(i == drop_row && cc == drop_col);
        code[cc][i] = !vld[cc][i] ? '0 : (fixed ? DW'(i) : DW'($urandom_range(0, 31)));
      end
    wr0   = wr_seen;
    done0 = done_cnt;

    @(posedge clk); #1;
    start = 1'b1; col_len = PW'(len); row_count = RCW'(rows); base_addr = AW'(base);
    @(posedge clk); #1;
    start = 1'b0; col_len = PW'($urandom); row_count = RCW'($urandom); base_addr = AW'($urandom);
    check_eq({tag, "_busy_at_start"}, busy, 1'b1);
    check_eq({tag, "_skew_cleared"}, skew_err, 1'b0);
    t0 = cyc + gap;

    // Model: row 0 is the column strobe; an active row disagreeing, or a strobe
    // beyond len, flags skew. The k-th strobe writes base+k, N cycles after row 0.
    k = 0; last_c = -1; exp_skew = 1'b0;
    for (int cc = 0; cc < ncols; cc++) begin
      s = vld[cc][0];
      for (int i = 0; i < rows; i++) if (vld[cc][i] != s) exp_skew = 1'b1;
      if (s) begin
        if (k < len) begin
          d = '0;
          for (int i = 0; i < rows; i++) d[(N-1-i)*DW +: DW] = code[cc][i];
          exp_q.push_back({AW'(base + k), d});
          exp_cyc_q.push_back(t0 + N + cc);
          last_c = cc;
          k++;
        end else begin
          exp_skew = 1'b1;
        end
      end
    end
    exp_done = t0 + N + last_c + 1;

    repeat (gap) begin @(posedge clk); #1; end
    for (int t = 0; t < ncols + N - 1; t++) begin
      pe_valid = '0; pe_dir = '0;
      for (int i = 0; i < N; i++) begin
        c = t - i;
        if (c >= 0 && c < ncols && vld[c][i]) begin
          pe_valid[i] = 1'b1;
          pe_dir[i*DW +: DW] = code[c][i];
        end
      end
      start = (t == 3);
      @(posedge clk); #1;
    end
    pe_valid = '0; pe_dir = '0; start = 1'b0;

    wait_n = 0;
    while (done_cnt == done0 && wait_n < 64) begin @(posedge clk); #1; wait_n++; end
    check_eq({tag, "_done_count"}, done_cnt - done0, 1);
    check_eq({tag, "_done_cycle"}, done_cyc, exp_done);
    check_eq({tag, "_writes"}, wr_seen - wr0, len);
    check_eq({tag, "_skew_err"}, skew_err, exp_skew);
    check_eq({tag, "_idle_after"}, busy, 1'b0);
    check_eq({tag, "_queue_drained"}, exp_q.size(), 0);
    exp_q.delete(); exp_cyc_q.delete();
  endtask

  task automatic run_zero();
    int wr0, done0, sc;
    wr0 = wr_seen; done0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; col_len = '0; row_count = RCW'(16); base_addr = AW'($urandom);
    @(posedge clk); #1;
    sc = cyc;
    check_eq("zero_busy", busy, 1'b1);
    check_eq("zero_done", done, 1'b1);
    col_len = PW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("zero_start_in_done_ignored", busy, 1'b0);
    check_eq("zero_done_one_cycle", done, 1'b0);
    repeat (N + 4) begin @(posedge clk); #1; end
    check_eq("zero_no_write", wr_seen - wr0, 0);
    check_eq("zero_done_count", done_cnt - done0, 1);
    check_eq("zero_done_cycle", done_cyc, sc);
  endtask

  task automatic run_reset_abort();
    logic [N*DW-1:0] d;
    int t0, c, done0;
    done0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; col_len = PW'(8); row_count = RCW'(16); base_addr = AW'(10'h100);
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    for (int cc = 0; cc < 2; cc++) begin
      d = '0;
      for (int i = 0; i < N; i++) d[(N-1-i)*DW +: DW] = DW'(cc*3 + i);
      exp_q.push_back({AW'(10'h100 + cc), d});
      exp_cyc_q.push_back(t0 + N + cc);
    end
    for (int t = 0; t < N + 2; t++) begin
      pe_valid = '0; pe_dir = '0;
      for (int i = 0; i < N; i++) begin
        c = t - i;
        if (c >= 0 && c < 8) begin
          pe_valid[i] = 1'b1;
          pe_dir[i*DW +: DW] = DW'(c*3 + i);
        end
      end
      @(posedge clk); #1;
    end
    check_eq("abort_col2_pending", mem_wen, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_wen", mem_wen, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_state", dbg_state, 2'd0);
    check_eq("abort_wdata", mem_wdata, '0);
    pe_valid = '0; pe_dir = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (N + 4) begin @(posedge clk); #1; end
    check_eq("abort_writes_before_rst", exp_q.size(), 0);
    check_eq("abort_no_done", done_cnt - done0, 0);
    exp_q.delete(); exp_cyc_q.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; col_len = '0; row_count = '0; base_addr = '0;
    pe_valid = '0; pe_dir = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wen", mem_wen, 1'b0);
    check_eq("rst_addr", mem_addr, '0);
    check_eq("rst_wdata", mem_wdata, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_skew", skew_err, 1'b0);
    rst = 1'b0;

    run_stripe(4, 16, 'h010, -1, 0, 0, 0, 1'b1, "ideal");
    run_stripe(3, 5, $urandom_range(0, 1023), -1, 0, 0, 1, 1'b0, "masked");
    run_stripe(4, 16, 'h3FE, -1, 0, 0, 2, 1'b0, "wrap");
    run_stripe(4, 16, 'h040, 7, 2, 0, 0, 1'b0, "drop7");
    run_stripe(3, 5, 'h080, 9, 1, 0, 0, 1'b0, "drop_masked");
    run_stripe(2, 16, 'h200, -1, 0, 1, 0, 1'b0, "extra");
    run_reset_abort();
    run_stripe(8, 16, 'h120, -1, 0, 0, 0, 1'b0, "after_rst");
    run_zero();
    run_stripe(1, 1, 'h3FF, -1, 0, 0, 3, 1'b0, "single");
    for (int n = 0; n < 8; n++)
      run_stripe($urandom_range(1, 8), $urandom_range(1, 16), $urandom_range(0, 1023),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : -1,
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
                 1'b0, $sformatf("rand%0d", n));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
